bcd_seg_scan: RTL and testbench

Multiplexed 4-position 7-segment display driver placed directly downstream of the 3-digit BCD counter top. Consumes the counter's three BCD digits and carry-out, snapshots them once per scan frame, and time-multiplexes them onto one shared segment bus with per-position anode enables. Position 3 shows a sticky overflow indicator ('1') so a counter wrap past 999 stays visible.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/bcd_seg_scan_if.sv | 23 ++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/bcd_seg_scan.sv | 150 +++++++++++++++
 tb/tb_bcd_seg_scan.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared glyph constants and slot state type for the bcd_seg_scan display driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied at the top.
package seg_pkg;

    typedef enum logic [1:0] {
        S_D0 = 2'd0,
        S_D1 = 2'd1,
        S_D2 = 2'd2,
        S_D3 = 2'd3
    } slot_t;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // All segments dark, expressed in the active-high glyph domain.
    localparam logic [6:0] SEG_ALL_OFF = 7'h00;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Bus between the BCD counter side and the multiplexed 7-segment display driver.
// master = counter/board side, slave = bcd_seg_scan.
interface bcd_seg_scan_if;
    logic [3:0] qout1;
    logic [3:0] qout2;
    logic [3:0] qout3;
    logic       cout;
    logic       clr_ovf;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ovf;

    modport master (
        output qout1, qout2, qout3, cout, clr_ovf,
        input  an, seg, dp, ovf
    );

    modport slave (
        input  qout1, qout2, qout3, cout, clr_ovf,
        output an, seg, dp, ovf
    );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-high 7-segment glyph; codes 10-15 render as a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_DASH;
        case (bcd)
            4'd0: glyph = GLYPH_0;
            4'd1: glyph = GLYPH_1;
            4'd2: glyph = GLYPH_2;
            4'd3: glyph = GLYPH_3;
            4'd4: glyph = GLYPH_4;
            4'd5: glyph = GLYPH_5;
            4'd6: glyph = GLYPH_6;
            4'd7: glyph = GLYPH_7;
            4'd8: glyph = GLYPH_8;
            4'd9: glyph = GLYPH_9;
            default: glyph = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// 4-position multiplexed 7-segment driver for a 3-digit BCD counter with sticky overflow.
// Optional build macro: LEAD_ZERO_BLANK_EN (blank leading zeros on positions 2 and 1).
module bcd_seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    bcd_seg_scan_if.slave   bus
);

    localparam int unsigned DIV_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_OFF_PIN = SEG_ACTIVE_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;
    localparam logic        DP_OFF_PIN  = SEG_ACTIVE_LOW;

    function automatic logic [6:0] to_pin(input logic [6:0] g);
        return SEG_ACTIVE_LOW ? ~g : g;
    endfunction

    logic [DIV_W-1:0] div;
    slot_t            slot;
    logic             ovf_q;
    logic [3:0]       sh_d0;
    logic [3:0]       sh_d1;
    logic [3:0]       sh_d2;
    logic             sh_ovf;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    logic             div_last;
    logic [3:0]       digit;
    logic [6:0]       dec_glyph;
    logic [6:0]       lit_glyph;
    logic [3:0]       lit_an;
    logic             blank1;
    logic             blank2;

    assign div_last = (div == DIV_LAST);

    bcd_to_seg u_dec (
        .bcd   (digit),
        .glyph (dec_glyph)
    );

    always_comb begin
        digit = sh_d0;
        case (slot)
            S_D1:    digit = sh_d1;
            S_D2:    digit = sh_d2;
            default: digit = sh_d0;
        endcase
    end

    // Leading-zero suppression never hides a digit once overflow is being shown.
`ifdef LEAD_ZERO_BLANK_EN
    always_comb begin
        blank2 = (sh_d2 == 4'd0) && !sh_ovf;
        blank1 = blank2 && (sh_d1 == 4'd0);
    end
`else
    always_comb begin
        blank2 = 1'b0;
        blank1 = 1'b0;
    end
`endif

    // Position 3 keeps its anode dark when there is nothing to show.
    always_comb begin
        lit_glyph = dec_glyph;
        lit_an    = 4'b1110;
        case (slot)
            S_D0: begin
                lit_glyph = dec_glyph;
                lit_an    = 4'b1110;
            end
            S_D1: begin
                lit_glyph = blank1 ? GLYPH_BLANK : dec_glyph;
                lit_an    = 4'b1101;
            end
            S_D2: begin
                lit_glyph = blank2 ? GLYPH_BLANK : dec_glyph;
                lit_an    = 4'b1011;
            end
            default: begin
                lit_glyph = sh_ovf ? GLYPH_1 : GLYPH_BLANK;
                lit_an    = sh_ovf ? 4'b0111 : 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div    <= '0;
            slot   <= S_D0;
            ovf_q  <= 1'b0;
            sh_d0  <= 4'd0;
            sh_d1  <= 4'd0;
            sh_d2  <= 4'd0;
            sh_ovf <= 1'b0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_OFF_PIN;
            dp_q   <= DP_OFF_PIN;
        end else begin
            div <= div_last ? '0 : div + DIV_W'(1);

            if (div_last) begin
                case (slot)
                    S_D0:    slot <= S_D1;
                    S_D1:    slot <= S_D2;
                    S_D2:    slot <= S_D3;
                    default: slot <= S_D0;
                endcase
            end

            // Frame-boundary snapshot keeps one frame's digits coherent.
            if (div_last && slot == S_D3) begin
                sh_d0  <= bus.qout1;
                sh_d1  <= bus.qout2;
                sh_d2  <= bus.qout3;
                sh_ovf <= ovf_q;
            end

            if (bus.cout) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end

            // Outputs track the upcoming div value; div==0 is the dead slot.
            if (div_last) begin
                an_q  <= 4'b1111;
                seg_q <= SEG_OFF_PIN;
            end else begin
                an_q  <= lit_an;
                seg_q <= to_pin(lit_glyph);
            end
            dp_q <= DP_OFF_PIN;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed-vector bench for bcd_seg_scan (SCAN_DIV=4, active-low segments).
`timescale 1ns/1ps
module tb_bcd_seg_scan;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    bcd_seg_scan_if bus ();

    bcd_seg_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    // Walks 16 edges from a frame boundary; glyph args are active-low pin values.
    task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input bit p3_lit);
        int d;
        int s;
        logic [3:0] ean;
        logic [6:0] eseg;
        for (int i = 0; i < 16; i++) begin
            tick();
            d = cyc % 4;
            s = (cyc / 4) % 4;
            if (d == 0) begin
                ean  = 4'b1111;
                eseg = 7'h7F;
            end else begin
                case (s)
                    0: begin ean = 4'b1110; eseg = e0; end
                    1: begin ean = 4'b1101; eseg = e1; end
                    2: begin ean = 4'b1011; eseg = e2; end
                    default: begin
                        ean  = p3_lit ? 4'b0111 : 4'b1111;
                        eseg = p3_lit ? 7'h79 : 7'h7F;
                    end
                endcase
            end
            check_vec($sformatf("frame_an_s%0d_d%0d", s, d), 32'(bus.an), 32'(ean));
            check_vec($sformatf("frame_seg_s%0d_d%0d", s, d), 32'(bus.seg), 32'(eseg));
        end
        check_vec("frame_dp", 32'(bus.dp), 32'd1);
    endtask

    initial begin
        bus.qout1   = 4'd0;
        bus.qout2   = 4'd0;
        bus.qout3   = 4'd0;
        bus.cout    = 1'b0;
        bus.clr_ovf = 1'b0;
        reset       = 1'b1;
        repeat (3) tick();
        check_vec("rst_an",  32'(bus.an),  32'hF);
        check_vec("rst_seg", 32'(bus.seg), 32'h7F);
        check_vec("rst_dp",  32'(bus.dp),  32'd1);
        check_vec("rst_ovf", 32'(bus.ovf), 32'd0);

        reset = 1'b0;
        cyc = 0;
        bus.qout3 = 4'd1;
        bus.qout2 = 4'd2;
        bus.qout1 = 4'd5;
        tick();
        check_vec("first_an",  32'(bus.an),  32'hE);
        check_vec("first_seg", 32'(bus.seg), 32'h40);

        // 1/2/5 captured at edge 16
        goto(16);
        check_frame(7'h12, 7'h24, 7'h79, 1'b0);

        // mid-frame change must not reach the display before the next snapshot
        goto(34);
        bus.qout1 = 4'd6;
        tick();
        check_vec("hold_seg", 32'(bus.seg), 32'h12);
        goto(48);
        check_frame(7'h02, 7'h24, 7'h79, 1'b0);

        // sticky overflow
        bus.cout = 1'b1;
        tick();
        check_vec("ovf_set", 32'(bus.ovf), 32'd1);
        bus.cout = 1'b0;
        tick();
        check_vec("ovf_sticky", 32'(bus.ovf), 32'd1);
        goto(80);
        check_frame(7'h02, 7'h24, 7'h79, 1'b1);

        bus.clr_ovf = 1'b1;
        bus.cout    = 1'b1;
        tick();
        check_vec("ovf_clr_with_cout", 32'(bus.ovf), 32'd1);
        bus.cout = 1'b0;
        tick();
        check_vec("ovf_clr", 32'(bus.ovf), 32'd0);
        bus.clr_ovf = 1'b0;

        // invalid BCD renders as dash
        bus.qout1 = 4'hB;
        goto(112);
        check_frame(7'h3F, 7'h24, 7'h79, 1'b0);

        // digits 0/0/7
        bus.qout3 = 4'd0;
        bus.qout2 = 4'd0;
        bus.qout1 = 4'd7;
        goto(144);
`ifdef LEAD_ZERO_BLANK_EN
        check_frame(7'h78, 7'h7F, 7'h7F, 1'b0);
`else
        check_frame(7'h78, 7'h40, 7'h40, 1'b0);
`endif

        // reset in slot 2
        goto(169);
        check_vec("pre_rst_an", 32'(bus.an), 32'hB);
        reset = 1'b1;
        tick();
        check_vec("midrst_an",  32'(bus.an),  32'hF);
        check_vec("midrst_seg", 32'(bus.seg), 32'h7F);
        check_vec("midrst_ovf", 32'(bus.ovf), 32'd0);
        reset = 1'b0;
        cyc = 0;
        tick();
        check_vec("postrst_an",  32'(bus.an),  32'hE);
        check_vec("postrst_seg", 32'(bus.seg), 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
